// File: rtl/icache_refill.sv
// Direct-mapped instruction cache with a word-by-word line refill engine.
// Hits are answered combinationally; a miss fetches the whole line from memory before answering.
module icache_refill #(
  parameter int INDEX_BIT  = 2,
  parameter int OFFSET_BIT = 2
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        flush,
  input  logic        fetch_valid,
  input  logic [31:0] fetch_addr,
  output logic        fetch_done,
  output logic [31:0] fetch_inst,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_data
);

  localparam int LINES   = 1 << INDEX_BIT;
  localparam int WORDS   = 1 << OFFSET_BIT;
  localparam int TAG_BIT = 32 - INDEX_BIT - OFFSET_BIT - 2;
  localparam int CNT_W   = (OFFSET_BIT > 0) ? OFFSET_BIT : 1;

  typedef enum logic {IDLE, REFILL} state_t;

  state_t               state;
  logic [CNT_W-1:0]     cnt;
  logic [LINES-1:0]     valid;
  logic [TAG_BIT-1:0]   refill_tag;
  logic [INDEX_BIT-1:0] refill_idx;

  logic [TAG_BIT-1:0]   tags [LINES];
  logic [31:0]          data [LINES][WORDS];

  logic [TAG_BIT-1:0]   f_tag;
  logic [INDEX_BIT-1:0] f_idx;
  logic [CNT_W-1:0]     f_off;
  logic                 hit;
  logic                 last;
  logic                 ack_word;

  assign f_tag = fetch_addr[31 -: TAG_BIT];
  assign f_idx = INDEX_BIT'(fetch_addr >> (OFFSET_BIT + 2));
  assign f_off = (OFFSET_BIT == 0) ? '0 : CNT_W'(fetch_addr >> 2);

  assign hit      = valid[f_idx] && (tags[f_idx] == f_tag);
  assign last     = (cnt == CNT_W'(WORDS - 1));
  assign ack_word = rdy_in && !flush && (state == REFILL) && mem_ack;

  assign fetch_done = (state == IDLE) && fetch_valid && hit && !flush;
  assign fetch_inst = data[f_idx][f_off];
  assign mem_req    = (state == REFILL);
  assign mem_addr   = mem_req ? ((32'({refill_tag, refill_idx}) << (OFFSET_BIT + 2)) | (32'(cnt) << 2))
                              : '0;

  // Control path: the only state that needs a defined value out of reset.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state      <= IDLE;
      cnt        <= '0;
      valid      <= '0;
      refill_tag <= '0;
      refill_idx <= '0;
    end else if (rdy_in) begin
      if (flush) begin
        valid <= '0;
        state <= IDLE;
        cnt   <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (fetch_valid && !hit) begin
              refill_tag   <= f_tag;
              refill_idx   <= f_idx;
              cnt          <= '0;
              // A line being overwritten must never hit while only partly filled.
              valid[f_idx] <= 1'b0;
              state        <= REFILL;
            end
          end
          REFILL: begin
            if (mem_ack) begin
              if (last) begin
                valid[refill_idx] <= 1'b1;
                cnt               <= '0;
                state             <= IDLE;
              end else begin
                cnt <= cnt + 1'b1;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // Storage arrays carry no reset; validity alone decides whether contents are used.
  always_ff @(posedge clk_in) begin
    if (ack_word) begin
      data[refill_idx][cnt] <= mem_data;
      if (last) tags[refill_idx] <= refill_tag;
    end
  end

endmodule
